// File: rtl/fft_pkg.sv
// Shared widths and the per-frame result record for the fft64 peak detector.
package fft_pkg;
  localparam int DW_DEF    = 11;
  localparam int LOG2N_DEF = 6;
  localparam int N_DEF     = 1 << LOG2N_DEF;
  localparam int SQW_DEF   = 2*DW_DEF - 1;      // one squared component
  localparam int PW_DEF    = 2*DW_DEF;          // |x|^2
  localparam int EW_DEF    = PW_DEF + LOG2N_DEF; // frame energy

  typedef struct packed {
    logic [LOG2N_DEF-1:0] peak_bin;
    logic [PW_DEF-1:0]    peak_pow;
    logic [EW_DEF-1:0]    frame_pow;
  } peak_rec_t;
endpackage

// File: rtl/cplx_pow.sv
// Registered squares of one complex sample; the sum is formed from the
// registered squares so |x|^2 is ready one edge after the sample is accepted.
module cplx_pow
  import fft_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 vld_i,
  input  logic signed [DW-1:0] xr,
  input  logic signed [DW-1:0] xi,
  output logic [2*DW-1:0]      pow_o
);
  localparam int SQW = 2*DW - 1;

  logic signed [SQW-1:0] xr_x, xi_x;
  logic [SQW-1:0]        sq_r_d, sq_r_q, sq_i_d, sq_i_q;

  // Sign-extend first so the product is formed at full width; (-2^(DW-1))^2
  // fits in SQW bits.
  assign xr_x = {{(SQW-DW){xr[DW-1]}}, xr};
  assign xi_x = {{(SQW-DW){xi[DW-1]}}, xi};

  always_comb begin
    sq_r_d = sq_r_q;
    sq_i_d = sq_i_q;
    if (vld_i) begin
      sq_r_d = xr_x * xr_x;
      sq_i_d = xi_x * xi_x;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sq_r_q <= '0;
      sq_i_q <= '0;
    end else begin
      sq_r_q <= sq_r_d;
      sq_i_q <= sq_i_d;
    end
  end

  assign pow_o = {1'b0, sq_r_q} + {1'b0, sq_i_q};
endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame power peak search and energy sum over 64-bin fft bursts.
// Build option PEAK_DC_MASK_EN: exclude bin 0 from the peak search.
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int LOG2N = LOG2N_DEF
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    valid_i,
  input  logic signed [DW-1:0]    xr,
  input  logic signed [DW-1:0]    xi,
  output logic                    valid_o,
  output logic [LOG2N-1:0]        peak_bin,
  output logic [2*DW-1:0]         peak_pow,
  output logic [2*DW+LOG2N-1:0]   frame_pow,
  output logic [7:0]              frame_cnt
);
  localparam int PW     = 2*DW;
  localparam int EW     = PW + LOG2N;
  localparam int STAGES = 2;

  logic [LOG2N-1:0]  bin_cnt_d, bin_cnt_q;
  logic [LOG2N-1:0]  bin1_d, bin1_q;
  logic              last1_d, last1_q;
  logic              last2_d, last2_q;
  logic [STAGES:0]   vld_pipe_d, vld_pipe_q;
  logic [PW-1:0]     pow;
  logic [EW-1:0]     acc_d, acc_q;
  logic [PW-1:0]     max_d, max_q;
  logic [LOG2N-1:0]  maxidx_d, maxidx_q;
  peak_rec_t         res_d, res_q;
  logic [7:0]        frame_cnt_d, frame_cnt_q;

  cplx_pow #(.DW(DW)) u_pow (
    .CLK   (CLK),
    .RST   (RST),
    .vld_i (valid_i),
    .xr    (xr),
    .xi    (xi),
    .pow_o (pow)
  );

  always_comb begin
    bin_cnt_d   = bin_cnt_q;
    bin1_d      = bin1_q;
    last1_d     = last1_q;
    acc_d       = acc_q;
    max_d       = max_q;
    maxidx_d    = maxidx_q;
    res_d       = res_q;
    frame_cnt_d = frame_cnt_q;

    // [0] squares registered, [1] accumulate done, [2] result pulse
    vld_pipe_d = {vld_pipe_q[1] & last2_q, vld_pipe_q[0], valid_i};
    last2_d    = vld_pipe_q[0] & last1_q;

    if (valid_i) begin
      bin_cnt_d = bin_cnt_q + 1'b1;
      bin1_d    = bin_cnt_q;
      last1_d   = (bin_cnt_q == '1);
    end

    if (vld_pipe_q[0]) begin
      if (bin1_q == '0) begin
        // Bin 0 restarts the frame, so a following frame never sees stale state.
        acc_d    = EW'(pow);
        maxidx_d = '0;
`ifdef PEAK_DC_MASK_EN
        max_d    = '0;
`else
        max_d    = pow;
`endif
      end else begin
        acc_d = acc_q + EW'(pow);
        if (pow > max_q) begin
          max_d    = pow;
          maxidx_d = bin1_q;
        end
      end
    end

    // Reads stage-2 state before the next frame's bin 0 overwrites it.
    if (vld_pipe_q[1] && last2_q) begin
      res_d.peak_bin  = maxidx_q;
      res_d.peak_pow  = max_q;
      res_d.frame_pow = acc_q;
      frame_cnt_d     = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bin_cnt_q   <= '0;
      bin1_q      <= '0;
      last1_q     <= 1'b0;
      last2_q     <= 1'b0;
      vld_pipe_q  <= '0;
      acc_q       <= '0;
      max_q       <= '0;
      maxidx_q    <= '0;
      res_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      bin_cnt_q   <= bin_cnt_d;
      bin1_q      <= bin1_d;
      last1_q     <= last1_d;
      last2_q     <= last2_d;
      vld_pipe_q  <= vld_pipe_d;
      acc_q       <= acc_d;
      max_q       <= max_d;
      maxidx_q    <= maxidx_d;
      res_q       <= res_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign valid_o   = vld_pipe_q[STAGES];
  assign peak_bin  = res_q.peak_bin;
  assign peak_pow  = res_q.peak_pow;
  assign frame_pow = res_q.frame_pow;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: doc/fft_peak_detect.md
Name: fft_peak_detect

Overview:
Downstream consumer of the fft64 output stream. It takes 64-bin bursts of complex samples (xr/xi, 11-bit signed) marked by a valid strobe. For each frame it computes per-bin power |X|^2, total frame energy, and the index and power of the strongest bin. It emits one result record per frame as a single-cycle pulse, for a downstream detector or host register block.

Parameters:
DW, 11, signed width of xr/xi samples
LOG2N, 6, log2 of bins per frame (frame length N = 2^LOG2N = 64)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  asynchronous, active-high reset
valid_i  in  1  sample strobe; one bin accepted per cycle it is high
xr  in  DW  bin real part, signed
xi  in  DW  bin imaginary part, signed
valid_o  out  1  one-cycle pulse: result fields updated this cycle
peak_bin  out  LOG2N  index (0..N-1) of maximum-power bin
peak_pow  out  2*DW  power of that bin, unsigned (22 bits at default)
frame_pow  out  2*DW+LOG2N  sum of all bin powers, unsigned (28 bits at default)
frame_cnt  out  8  frames completed since reset, wraps 255->0

Behaviour:
- Reset (RST high, async): valid_o=0, peak_bin=0, peak_pow=0, frame_pow=0, frame_cnt=0, bin counter=0, pipeline valids=0. A partial frame in progress is discarded.
- Bin counter: LOG2N bits, increments on each edge with valid_i=1, wraps N-1->0. Bin index = counter value when the sample is accepted. Gaps (valid_i=0) are allowed anywhere and only stall the counter.
- Stage 1 (edge k, valid_i=1): register sq_r=xr*xr and sq_i=xi*xi (signed multiply, 2*DW-1 bit unsigned results). Also register the bin index, a last flag (bin==N-1) and a stage valid.
- Stage 2 (edge k+1, stage-1 valid): pow=sq_r+sq_i (2*DW bits, no overflow; max 2^21 at default).
  - Bin 0: acc<=pow, max<=pow, maxidx<=0 (restart; no dependence on the previous frame).
  - Other bins: acc<=acc+pow. If pow > max (strict): max<=pow, maxidx<=bin. Ties keep the lower index.
  - Accumulator is 2*DW+LOG2N bits and cannot overflow.
- Stage 3 (edge k+2, stage-2 valid and last): peak_bin/peak_pow/frame_pow <= final values including bin N-1; frame_cnt++; valid_o=1 for exactly one cycle.
- Latency: valid_o rises 2 edges after the edge that accepts bin N-1. If valid_i gaps occur after bin N-1, latency is unchanged.
- Outputs hold until the next frame result. valid_o is never high two cycles in a row.
- Back-to-back frames: bin 0 of frame n+1 on the edge right after bin 63 of frame n must not corrupt frame n's result. The stage-2 restart on bin 0 plus the stage-3 capture provide this. Sustained throughput is 1 bin/cycle, no stall output.
- Fully sequential design; no combinational path from inputs to outputs.
- Most negative input (-1024) must square correctly to 1048576.

Optional Feature:
PEAK_DC_MASK_EN
- Defined: bin 0 is excluded from the peak search. At bin 0, max<=0 and maxidx<=0, and bin 0 still adds to frame_pow. peak_bin is then in 1..N-1 unless all other bins have power 0, in which case peak_bin=0 and peak_pow=0.
- Undefined: bin 0 competes like any other bin (default behaviour above).

Decomposition:
- Package fft_pkg: DW/LOG2N defaults, N constant, power/energy width localparams, typedef for the result record {peak_bin, peak_pow, frame_pow}.
- One sub-module, cplx_pow: 1-cycle registered |x|^2 (stage 1 plus the stage-2 add). The compare/accumulate/count logic stays in the top level.

Test Plan:
- Single frame, bin 5 = (300,-400), all others (1,1) -> valid_o 2 edges after bin 63; peak_bin=5, peak_pow=250000, frame_pow=250000+63*2=250126, frame_cnt=1.
- All 64 bins = (-1024,-1024) -> peak_pow=2097152, frame_pow=134217728 (2^27), peak_bin=0 (tie rule).
- Two frames back-to-back with no gap: frame A peak bin 10=(100,0), frame B peak bin 40=(0,-50) -> two valid_o pulses 64 cycles apart; results (10,10000) then (40,2500); frame_cnt 1 then 2.
- Random valid_i gaps (~50% duty) on the frame from test 1 -> identical results; valid_o exactly 2 edges after the bin-63 edge.
- RST asserted mid-frame at bin 30, then a fresh full frame -> outputs zero during reset; no pulse for the partial frame; next result correct with frame_cnt=1.
- PEAK_DC_MASK_EN defined, bin0=(500,0), bin 7=(10,10) -> peak_bin=7, peak_pow=200, frame_pow includes 250000.
